// File: rtl/fsm_pkg.sv
// Shared types and limits for the serial fsm stages.
// The deserializer state encoding lives here so neighbouring stages can decode it.
package fsm_pkg;

    typedef enum logic {
        DS_IDLE  = 1'b0,
        DS_SHIFT = 1'b1
    } deser_state_t;

    localparam int DESER_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_word_deser_slot.sv
// One-entry valid/ready holding register.
// A load that arrives while the slot cannot be freed is refused and flagged on drop.
module word_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             drop
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             free;

    // The slot counts as free when its current word is consumed this very cycle.
    assign free = ~valid_reg | ready;
    assign drop = load & ~free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (load && free) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/serial_word_deser.sv
// LSB-first serial-to-parallel word collector framed by a start-of-frame strobe,
// with sticky overrun and frame-error flags.
module serial_word_deser
    import fsm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    deser_state_t     state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] shifted;
    logic             overrun_reg, overrun_next;
    logic             frame_err_reg, frame_err_next;
    logic             word_done;
    logic             frame_set;
    logic             slot_drop;

    // New bits enter at the top so that after WIDTH shifts the sof bit lands in bit 0.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shifted[gi] = sr_reg[gi+1];
        end
    endgenerate
    assign shifted[WIDTH-1] = bit_in;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sr_next    = sr_reg;
        word_done  = 1'b0;
        frame_set  = 1'b0;
        case (state_reg)
            DS_IDLE: begin
                if (bit_valid && sof) begin
                    sr_next    = shifted;
                    cnt_next   = CW'(1);
                    state_next = DS_SHIFT;
                end
            end
            DS_SHIFT: begin
                if (bit_valid) begin
                    sr_next = shifted;
                    if (sof) begin
                        // Truncated frame: restart the count on this bit.
                        frame_set = 1'b1;
                        cnt_next  = CW'(1);
                    end else if (cnt_reg == LAST_IDX) begin
                        word_done  = 1'b1;
                        cnt_next   = '0;
                        state_next = DS_IDLE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = DS_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Setting beats clearing when both happen in the same cycle.
    always_comb begin
        overrun_next   = overrun_reg;
        frame_err_next = frame_err_reg;
        if (clr_err) begin
            overrun_next   = 1'b0;
            frame_err_next = 1'b0;
        end
        if (slot_drop) begin
            overrun_next = 1'b1;
        end
        if (frame_set) begin
            frame_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= DS_IDLE;
            cnt_reg       <= '0;
            sr_reg        <= '0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sr_reg        <= sr_next;
            overrun_reg   <= overrun_next;
            frame_err_reg <= frame_err_next;
        end
    end

    word_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (word_done),
        .load_data(shifted),
        .ready    (word_ready),
        .data     (word_data),
        .valid    (word_valid),
        .drop     (slot_drop)
    );

    assign busy      = (state_reg == DS_SHIFT);
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_serial_word_deser.sv
// Directed bench for serial_word_deser (WIDTH=8): framing, handshake, flags, reset.
module tb_serial_word_deser;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       sof;
    logic [7:0] word_data;
    logic       word_valid;
    logic       word_ready;
    logic       busy;
    logic       overrun;
    logic       frame_err;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    serial_word_deser #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .word_data (word_data),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Snapshot of every output, one line per completed check group.
    task automatic chk_all(input string tag, input logic [7:0] d, input logic v,
                           input logic b, input logic ov, input logic fe);
        chk({tag, ".data"}, 32'(word_data), 32'(d));
        chk({tag, ".valid"}, 32'(word_valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
        $display("[%0t] %s data=%02h valid=%0b busy=%0b ovr=%0b ferr=%0b",
                 $time, tag, word_data, word_valid, busy, overrun, frame_err);
    endtask

    // Drive nbits bits LSB-first at negedges; ends on a negedge with bit_valid low.
    task automatic send_bits(input logic [7:0] data, input int nbits, input bit first_sof,
                             input bit gap, input bit chk_busy);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (chk_busy && i > 0) chk("busy_mid", 32'(busy), 32'd1);
            bit_in    = data[i];
            bit_valid = 1'b1;
            sof       = (first_sof && i == 0);
            if (gap && i < nbits - 1) begin
                @(negedge clk);
                bit_valid = 1'b0;
                sof       = 1'b0;
                if (chk_busy) chk("busy_gap", 32'(busy), 32'd1);
            end
        end
        @(negedge clk);
        bit_valid = 1'b0;
        sof       = 1'b0;
        bit_in    = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sof        = 1'b0;
        word_ready = 1'b1;
        clr_err    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic frame 0xFA, one-cycle valid pulse with ready held high
        send_bits(8'hFA, 8, 1'b1, 1'b0, 1'b0);
        chk_all("word_fa", 8'hFA, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("fa_pulse_end", 8'hFA, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gapped bit_valid, busy checked throughout
        send_bits(8'hFA, 8, 1'b1, 1'b1, 1'b1);
        chk_all("word_fa_gap", 8'hFA, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Slot full: second word dropped, overrun set
        word_ready = 1'b0;
        send_bits(8'hA5, 8, 1'b1, 1'b0, 1'b0);
        chk_all("word_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'h3C, 8, 1'b1, 1'b0, 1'b0);
        chk_all("overrun_3c", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        word_ready = 1'b1;
        @(negedge clk);
        chk_all("a5_consumed", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk_all("ovr_cleared", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Truncated frame then 0x81
        send_bits(8'h07, 3, 1'b1, 1'b0, 1'b0);
        chk_all("partial3", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        send_bits(8'h81, 8, 1'b1, 1'b0, 1'b0);
        chk_all("word_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk_all("ferr_cleared", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);

        // clr_err coincident with a new sof error: set wins
        send_bits(8'h02, 3, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        sof       = 1'b1;
        clr_err   = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        sof       = 1'b0;
        clr_err   = 1'b0;
        chk_all("ferr_set_wins", 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
        send_bits(8'h00, 7, 1'b0, 1'b0, 1'b0);
        chk_all("word_01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;

        // Stray bits in IDLE ignored, then 0x0F
        send_bits(8'hFF, 3, 1'b0, 1'b0, 1'b0);
        chk_all("idle_stray", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h0F, 8, 1'b1, 1'b0, 1'b0);
        chk_all("word_0f", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-word with a full slot
        word_ready = 1'b0;
        send_bits(8'h12, 8, 1'b1, 1'b0, 1'b0);
        chk_all("word_12", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(8'h1F, 5, 1'b1, 1'b0, 1'b0);
        chk_all("pre_rst", 8'h12, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst        = 1'b0;
        word_ready = 1'b1;
        send_bits(8'h55, 8, 1'b1, 1'b0, 1'b0);
        chk_all("word_55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
